// File: rtl/env_sequencer.sv
// env_sequencer: ADSR-style envelope sequencer for the synth voice.
// A gate (trigger) starts an attack ramp to full scale, decays to the sustain
// level, holds there while the gate stays high, and releases to zero after the
// gate drops. Each ramp advances by STEP once per rate tick. The tick period
// comes from attack/decay/fade, all sampled live every cycle.
//
// Build option: define ENV_SEQUENCER_RETRIGGER_EN for hard retrigger (level
// cleared on every rising gate). Without it, a rising gate keeps the current
// level and ramps up from there (legato).
//
// state   | meaning
// IDLE    | silent, level held at 0, waiting for a rising gate
// ATTACK  | ramping up by STEP per tick until 0xFFFF
// DECAY   | ramping down by STEP per tick until the sustain level
// SUSTAIN | level follows the sustain input every cycle
// RELEASE | ramping down by STEP per tick until 0, then pulse env_done

module env_sequencer #(
    parameter logic [15:0] STEP = 16'd1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        trigger,
    input  logic [26:0] attack,
    input  logic [26:0] decay,
    input  logic [26:0] fade,
    input  logic [15:0] sustain,
    output logic [15:0] env_level,
    output logic [2:0]  env_state,
    output logic        env_active,
    output logic        env_done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] level_q, level_d;
    logic [26:0] cnt_q, cnt_d;
    logic        trig_q;
    logic        done_q, done_d;
    logic        active_q;

    logic        rise, fall;
    logic [26:0] period, period_eff, period_last;
    logic        counting, tick;
    logic [16:0] level_up, level_dn;
    logic [15:0] attack_lvl, decay_lvl, release_lvl;
    logic        gate_held_state;

    assign rise = trigger & ~trig_q;
    assign fall = ~trigger & trig_q;

    // Select the tick period for the current ramping state
    always_comb begin
        period   = 27'd1;
        counting = 1'b0;
        case (state_q)
            ST_ATTACK: begin
                period   = attack;
                counting = 1'b1;
            end
            ST_DECAY: begin
                period   = decay;
                counting = 1'b1;
            end
            ST_RELEASE: begin
                period   = fade;
                counting = 1'b1;
            end
            default: begin
                period   = 27'd1;
                counting = 1'b0;
            end
        endcase
    end

    // A zero period behaves as one (tick every cycle). Comparing with >= lets
    // a shortened period take effect immediately on the running count.
    assign period_eff  = (period == 27'd0) ? 27'd1 : period;
    assign period_last = period_eff - 27'd1;
    assign tick        = counting & (cnt_q >= period_last);

    // Saturating ramp candidates, computed one bit wider to catch wrap
    assign level_up    = {1'b0, level_q} + {1'b0, STEP};
    assign level_dn    = {1'b0, level_q} - {1'b0, STEP};
    assign attack_lvl  = level_up[16] ? 16'hFFFF : level_up[15:0];
    assign decay_lvl   = (level_dn[16] || (level_dn[15:0] <= sustain)) ? sustain : level_dn[15:0];
    assign release_lvl = level_dn[16] ? 16'h0000 : level_dn[15:0];

    assign gate_held_state = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                             (state_q == ST_SUSTAIN);

    // Next state and level; a rising gate outranks everything else
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        if (rise) begin
            state_d = ST_ATTACK;
`ifdef ENV_SEQUENCER_RETRIGGER_EN
            level_d = 16'h0000;
`else
            if (state_q == ST_IDLE) begin
                level_d = 16'h0000;
            end
`endif
        end else if (fall && gate_held_state) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ATTACK: begin
                    if (tick) begin
                        level_d = attack_lvl;
                        if (attack_lvl == 16'hFFFF) begin
                            state_d = ST_DECAY;
                        end
                    end
                end
                ST_DECAY: begin
                    // Already at or below target: settle without waiting a tick
                    if (level_q <= sustain) begin
                        level_d = sustain;
                        state_d = ST_SUSTAIN;
                    end else if (tick) begin
                        level_d = decay_lvl;
                        if (decay_lvl == sustain) begin
                            state_d = ST_SUSTAIN;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    level_d = sustain;
                end
                ST_RELEASE: begin
                    if (level_q == 16'h0000) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        level_d = release_lvl;
                        if (release_lvl == 16'h0000) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 16'h0000;
                end
            endcase
        end
    end

    // Rate counter restarts on every state change, on every tick, and rests at 0
    // in the non-ramping states
    always_comb begin
        if ((state_d != state_q) || !counting || tick) begin
            cnt_d = 27'd0;
        end else begin
            cnt_d = cnt_q + 27'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            level_q  <= 16'h0000;
            cnt_q    <= 27'd0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            trig_q   <= trigger;
            done_q   <= done_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign env_level  = level_q;
    assign env_state  = state_q;
    assign env_active = active_q;
    assign env_done   = done_q;

endmodule

// File: tb/tb_env_sequencer.sv
// tb_env_sequencer: directed envelope scenarios followed by randomized gate,
// period and sustain activity. A behavioural model predicts the outputs after
// each clock edge; a monitor pops those predictions and compares them with the
// DUT on the falling edge. Build with ENV_SEQUENCER_RETRIGGER_EN for the hard
// retrigger variant.

module tb_env_sequencer;

    localparam logic [15:0] STEP = 16'h1000;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
`ifdef ENV_SEQUENCER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        trigger = 1'b0;
    logic [26:0] attack = 27'd3;
    logic [26:0] decay = 27'd1;
    logic [26:0] fade = 27'd2;
    logic [15:0] sustain = 16'h8000;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        env_active;
    logic        env_done;

    env_sequencer #(.STEP(STEP)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .trigger   (trigger),
        .attack    (attack),
        .decay     (decay),
        .fade      (fade),
        .sustain   (sustain),
        .env_level (env_level),
        .env_state (env_state),
        .env_active(env_active),
        .env_done  (env_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] lvl;
        logic        act;
        logic        done;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: plain integer envelope arithmetic
    int m_phase = S_IDLE;
    int m_level = 0;
    int m_since = 0;   // cycles since the last tick or phase entry
    bit m_gate = 1'b0;
    bit m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic obs_t model_step();
        obs_t o;
        int   p, nxt, lvl, stp, sus;
        bit   rise, fall, tick, ramping, done;
        stp = int'(STEP);
        sus = int'(sustain);
        if (!wb_rst_ni) begin
            m_phase = S_IDLE;
            m_level = 0;
            m_since = 0;
            m_gate  = 1'b0;
            m_done  = 1'b0;
        end else begin
            rise   = trigger && !m_gate;
            fall   = !trigger && m_gate;
            m_gate = trigger;
            p = (m_phase == S_ATT) ? int'(attack) : (m_phase == S_DEC) ? int'(decay) : int'(fade);
            if (p < 1) p = 1;
            ramping = (m_phase == S_ATT) || (m_phase == S_DEC) || (m_phase == S_REL);
            tick = ramping && (m_since + 1 >= p);
            nxt  = m_phase;
            lvl  = m_level;
            done = 1'b0;
            if (rise) begin
                nxt = S_ATT;
                if (RETRIG || m_phase == S_IDLE) lvl = 0;
            end else if (fall && (m_phase == S_ATT || m_phase == S_DEC || m_phase == S_SUS)) begin
                nxt = S_REL;
            end else if (m_phase == S_ATT) begin
                if (tick) begin
                    lvl = (m_level + stp > 65535) ? 65535 : m_level + stp;
                    if (lvl == 65535) nxt = S_DEC;
                end
            end else if (m_phase == S_DEC) begin
                if (m_level <= sus) begin
                    lvl = sus;
                    nxt = S_SUS;
                end else if (tick) begin
                    lvl = (m_level - stp < sus) ? sus : m_level - stp;
                    if (lvl == sus) nxt = S_SUS;
                end
            end else if (m_phase == S_SUS) begin
                lvl = sus;
            end else if (m_phase == S_REL) begin
                if (m_level == 0 || tick) begin
                    lvl = (m_level - stp < 0) ? 0 : m_level - stp;
                    if (lvl == 0) begin
                        nxt  = S_IDLE;
                        done = 1'b1;
                    end
                end
            end
            m_since = (nxt != m_phase || !ramping || tick) ? 0 : m_since + 1;
            m_phase = nxt;
            m_level = lvl;
            m_done  = done;
        end
        o.st   = 3'(m_phase);
        o.lvl  = 16'(m_level);
        o.act  = (m_phase != S_IDLE);
        o.done = m_done;
        return o;
    endfunction

    // One clock: predict, advance past the edge, hand prediction to the monitor
    task automatic step();
        obs_t e;
        e = model_step();
        @(posedge wb_clk_i);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic run_until(input int st, input int limit, input string name);
        int n;
        n = 0;
        while (env_state != 3'(st) && n < limit) begin
            step();
            n++;
        end
        check({name, "_reached"}, env_state, st);
    endtask

    // Scoreboard monitor
    always @(negedge wb_clk_i) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {env_state, env_level, env_active, env_done}, e);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_l;

        // Reset
        repeat (3) step();
        check("reset_state", env_state, S_IDLE);
        check("reset_level", env_level, 0);
        check("reset_active", env_active, 0);
        check("reset_done", env_done, 0);
        wb_rst_ni = 1'b1;
        repeat (2) step();

        // Attack from idle, period 3
        trigger = 1'b1;
        step();
        check("attack_entry_state", env_state, S_ATT);
        check("attack_entry_level", env_level, 0);
        check("attack_entry_active", env_active, 1);
        repeat (2) step();
        check("attack_before_tick", env_level, 0);
        step();
        check("attack_first_tick", env_level, 32'h1000);
        repeat (45) step();
        check("attack_peak_level", env_level, 32'hFFFF);
        check("attack_to_decay", env_state, S_DEC);

        // Decay every cycle to 0x8000
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_l = 32'hFFFF - 32'(i) * 32'h1000;
            check("decay_ramp", env_level, exp_l);
        end
        step();
        check("decay_floor_level", env_level, 32'h8000);
        check("decay_to_sustain", env_state, S_SUS);
        step();
        check("sustain_hold", env_level, 32'h8000);
        sustain = 16'h4000;
        step();
        check("sustain_track", env_level, 32'h4000);
        sustain = 16'h8000;
        step();
        check("sustain_track_back", env_level, 32'h8000);

        // Release with period 2
        trigger = 1'b0;
        fade = 27'd2;
        step();
        check("release_entry_state", env_state, S_REL);
        check("release_entry_level", env_level, 32'h8000);
        repeat (15) step();
        check("release_late_level", env_level, 32'h1000);
        check("release_late_done", env_done, 0);
        step();
        check("release_end_state", env_state, S_IDLE);
        check("release_end_level", env_level, 0);
        check("release_end_done", env_done, 1);
        check("release_end_active", env_active, 0);
        step();
        check("done_single_cycle", env_done, 0);

        // Fast attack, decay to 0x3000, retrigger from release
        attack = 27'd0;
        decay = 27'd0;
        sustain = 16'h3000;
        fade = 27'd100;
        trigger = 1'b1;
        step();
        check("fast_attack_entry", env_state, S_ATT);
        step();
        check("fast_attack_tick", env_level, 32'h1000);
        run_until(S_SUS, 60, "sustain_3000");
        check("sustain_3000_level", env_level, 32'h3000);
        trigger = 1'b0;
        step();
        check("release_3000_state", env_state, S_REL);
        check("release_3000_level", env_level, 32'h3000);
        trigger = 1'b1;
        step();
        check("retrigger_state", env_state, S_ATT);
        check("retrigger_level", env_level, RETRIG ? 32'h0 : 32'h3000);

        // Sustain at full scale, then release from level 0
        sustain = 16'hFFFF;
        run_until(S_DEC, 40, "decay_full");
        check("decay_full_level", env_level, 32'hFFFF);
        step();
        check("decay_one_cycle", env_state, S_SUS);
        check("decay_one_cycle_level", env_level, 32'hFFFF);
        sustain = 16'h0000;
        step();
        check("sustain_zero", env_level, 0);
        trigger = 1'b0;
        step();
        check("release_zero_state", env_state, S_REL);
        step();
        check("release_zero_idle", env_state, S_IDLE);
        check("release_zero_done", env_done, 1);

        // Reset mid-decay, gate held through reset
        attack = 27'd3;
        decay = 27'd50;
        sustain = 16'h2000;
        trigger = 1'b1;
        step();
        run_until(S_DEC, 100, "pre_reset_decay");
        repeat (5) step();
        check("pre_reset_state", env_state, S_DEC);
        wb_rst_ni = 1'b0;
        step();
        check("rst_state", env_state, S_IDLE);
        check("rst_level", env_level, 0);
        check("rst_active", env_active, 0);
        check("rst_done", env_done, 0);
        step();
        check("rst_hold_state", env_state, S_IDLE);
        wb_rst_ni = 1'b1;
        step();
        check("post_rst_attack", env_state, S_ATT);
        check("post_rst_active", env_active, 1);

        // Randomized activity
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) trigger = ~trigger;
            if ($urandom_range(0, 49) == 0) begin
                attack = 27'($urandom_range(0, 4));
                decay  = 27'($urandom_range(0, 4));
                fade   = 27'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 29) == 0) sustain = 16'($urandom);
            wb_rst_ni = ($urandom_range(0, 499) != 0);
            step();
        end

        @(negedge wb_clk_i);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
